debounce_edge: RTL and testbench
================================

Name: debounce_edge

Overview:
Consumes the synchronized, idle-high output of the input synchronizer stage and produces a glitch-filtered level. Also produces single-cycle rise/fall strobes, a measurement of each debounced low pulse's width, and a running event count. It sits directly downstream of the synchronizer on every asynchronous discrete input, for example detector triggers and external strobes. All logic is in the single clk domain.

Parameters:
DB_CYCLES, 16, number of consecutive samples that must disagree with the current level before it changes; legal range 2..255.
CNT_W, 16, width of the low-pulse width counter (saturating).
EVT_W, 8, width of the falling-event counter (wrapping).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous, active-low reset.
sync_in  input  1  synchronized input level, idle high; already in the clk domain.
clr  input  1  synchronous clear of the measurement and count outputs.
level_out  output  1  debounced level.
fall_pulse  output  1  one-cycle strobe when level_out goes 1->0.
rise_pulse  output  1  one-cycle strobe when level_out goes 0->1.
width_out  output  CNT_W  latched width of the last completed low pulse, in clk cycles.
width_vld  output  1  one-cycle strobe when width_out updates.
evt_cnt  output  EVT_W  count of falling events.
evt_ovf  output  1  sticky flag: evt_cnt has wrapped.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - level_out=1, state=HI.
  - Filter counter=0, width counter=0.
  - All strobes=0, width_out=0, evt_cnt=0, evt_ovf=0.
- States (2-bit):
  - HI: level 1, stable.
  - FILT_LO: level 1, counting low samples.
  - LO: level 0, stable.
  - FILT_HI: level 0, counting high samples.
- HI: sync_in==0 -> FILT_LO, filter counter=1.
- FILT_LO:
  - sync_in==1 -> HI, filter counter=0. Glitch rejected, no output activity.
  - sync_in==0 and filter counter==DB_CYCLES-1 -> LO. At the same edge: level_out<=0, fall_pulse<=1, width counter<=1.
  - Otherwise increment the filter counter.
- LO and FILT_HI mirror HI and FILT_LO with the polarity inverted. On FILT_HI completion: level_out<=1, rise_pulse<=1, width_out<=width counter, width_vld<=1.
- Latency: if sync_in is low for samples at edges k..k+DB_CYCLES-1, then level_out is 0 and fall_pulse is 1 in the cycle after edge k+DB_CYCLES-1. Rise timing is symmetric.
- Width rule:
  - The width counter increments every cycle level_out==0 and saturates at all-ones (no wrap).
  - width_out equals the number of cycles level_out was 0.
  - Because debounce delay is symmetric, a clean input low of N>=DB_CYCLES cycles gives width_out=N.
- Strobes are high for exactly one cycle. fall_pulse and rise_pulse are never high in the same cycle.
- Event count:
  - evt_cnt increments on each fall_pulse cycle and wraps from all-ones to 0.
  - evt_ovf is set on that wrap and stays set until clr or reset.
- clr behaviour:
  - Zeroes evt_cnt, evt_ovf and width_out, and forces width_vld=0.
  - clr has priority over a simultaneous fall_pulse increment or width latch; that event is lost.
  - clr does not affect the state machine, level_out or the in-progress width counter.
- Reset mid-pulse: all state is discarded and level_out returns to 1 with no strobes. A low sync_in held after reset must re-qualify for DB_CYCLES samples.
- Input chatter inside FILT_* restarts qualification. A low pulse shorter than DB_CYCLES produces no output at all.

Decomposition:
- Shared package/include: state encodings, the default debounce constant, and the CNT_W/EVT_W defaults used by all discrete-input channels.
- One natural sub-module, glitch_filter, which contains the filter counter, the state machine and level_out/strobe generation.
- The top level adds the width counter, the event counter and the clr logic.

Test Plan:
- Reset, then sync_in held at 1 for 100 cycles -> level_out=1, no strobes, evt_cnt=0, width_out=0.
- DB_CYCLES=16, sync_in low for 15 cycles then high -> no fall_pulse, level_out stays 1.
- DB_CYCLES=16, sync_in low for 40 cycles then high:
  - fall_pulse occurs 16 cycles after the first low sample.
  - rise_pulse and width_vld occur 16 cycles after the first high sample.
  - width_out=40 and evt_cnt=1.
- CNT_W=4, low pulse of 100 cycles -> width_out=15 (saturated).
- EVT_W=2, five qualified low pulses -> evt_cnt=1, evt_ovf=1. Then pulse clr -> evt_cnt=0, evt_ovf=0, while level_out is unchanged.
- Assert rst_n low during LO, then release with sync_in held at 0 -> level_out=1 immediately. fall_pulse follows DB_CYCLES cycles after release and evt_cnt=1.

Source files
------------

// File: rtl/debounce_edge_pkg.sv
// Shared definitions for the discrete-input debounce channels: filter state
// encoding and the default filter/counter sizing.
package debounce_edge_pkg;

  typedef enum logic [1:0] {
    ST_HI      = 2'd0,
    ST_FILT_LO = 2'd1,
    ST_LO      = 2'd2,
    ST_FILT_HI = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_DEF = 16;
  localparam int CNT_W_DEF     = 16;
  localparam int EVT_W_DEF     = 8;

  // Filter counter only has to reach DB_CYCLES-1, and DB_CYCLES tops out at 255.
  localparam int FILT_W = 8;

endpackage

// File: rtl/debounce_edge_if.sv
// Bundle of the debounced-channel signals: synchronized input and clear
// towards the block, filtered level, strobes and measurements back out.
interface debounce_edge_if
  import debounce_edge_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EVT_W = EVT_W_DEF
);

  logic             sync_in;
  logic             clr;
  logic             level_out;
  logic             fall_pulse;
  logic             rise_pulse;
  logic [CNT_W-1:0] width_out;
  logic             width_vld;
  logic [EVT_W-1:0] evt_cnt;
  logic             evt_ovf;

  modport master (
    output sync_in, clr,
    input  level_out, fall_pulse, rise_pulse, width_out, width_vld, evt_cnt, evt_ovf
  );

  modport slave (
    input  sync_in, clr,
    output level_out, fall_pulse, rise_pulse, width_out, width_vld, evt_cnt, evt_ovf
  );

endinterface

// File: rtl/debounce_edge_glitch_filter.sv
// Debounce state machine: a level change needs DB_CYCLES consecutive
// disagreeing samples; emits registered level/strobes plus same-edge event flags.
module debounce_edge_glitch_filter
  import debounce_edge_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic level_out,
  output logic fall_pulse,
  output logic rise_pulse,
  output logic fall_evt,
  output logic rise_evt
);

  localparam logic [FILT_W-1:0] LAST = FILT_W'(DB_CYCLES - 1);

  db_state_t         state_reg, state_next;
  logic [FILT_W-1:0] cnt_reg, cnt_next;
  logic              level_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_HI;
      cnt_reg    <= '0;
      level_out  <= 1'b1;
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      level_out  <= level_next;
      fall_pulse <= fall_evt;
      rise_pulse <= rise_evt;
    end
  end

  // fall_evt/rise_evt mark the edge at which the level flips, so the parent
  // can update its counters in the same cycle the strobes become visible.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_out;
    fall_evt   = 1'b0;
    rise_evt   = 1'b0;
    case (state_reg)
      ST_HI: begin
        if (!sync_in) begin
          state_next = ST_FILT_LO;
          cnt_next   = FILT_W'(1);
        end
      end
      ST_FILT_LO: begin
        if (sync_in) begin
          state_next = ST_HI;
          cnt_next   = '0;
        end else if (cnt_reg == LAST) begin
          state_next = ST_LO;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_evt   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_LO: begin
        if (sync_in) begin
          state_next = ST_FILT_HI;
          cnt_next   = FILT_W'(1);
        end
      end
      ST_FILT_HI: begin
        if (!sync_in) begin
          state_next = ST_LO;
          cnt_next   = '0;
        end else if (cnt_reg == LAST) begin
          state_next = ST_HI;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_evt   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_HI;
        cnt_next   = '0;
        level_next = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/debounce_edge.sv
// Debounced discrete input: glitch filter plus low-pulse width measurement
// and a wrapping falling-event counter with sticky overflow.
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int EVT_W     = EVT_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  debounce_edge_if.slave bus
);

  logic             level;
  logic             fall_pulse;
  logic             rise_pulse;
  logic             fall_evt;
  logic             rise_evt;
  logic [CNT_W-1:0] width_cnt_reg;
  logic [CNT_W-1:0] width_out_reg;
  logic             width_vld_reg;
  logic [EVT_W-1:0] evt_cnt_reg;
  logic             evt_ovf_reg;

  debounce_edge_glitch_filter #(
    .DB_CYCLES (DB_CYCLES)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_in    (bus.sync_in),
    .level_out  (level),
    .fall_pulse (fall_pulse),
    .rise_pulse (rise_pulse),
    .fall_evt   (fall_evt),
    .rise_evt   (rise_evt)
  );

  // Starts at 1 on the falling edge so the latched value equals the number
  // of cycles level_out spent low; clr deliberately leaves it running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt_reg <= '0;
    end else if (fall_evt) begin
      width_cnt_reg <= CNT_W'(1);
    end else if (!level && (width_cnt_reg != '1)) begin
      width_cnt_reg <= width_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_out_reg <= '0;
      width_vld_reg <= 1'b0;
      evt_cnt_reg   <= '0;
      evt_ovf_reg   <= 1'b0;
    end else if (bus.clr) begin
      width_out_reg <= '0;
      width_vld_reg <= 1'b0;
      evt_cnt_reg   <= '0;
      evt_ovf_reg   <= 1'b0;
    end else begin
      width_vld_reg <= rise_evt;
      if (rise_evt) begin
        width_out_reg <= width_cnt_reg;
      end
      if (fall_evt) begin
        evt_cnt_reg <= evt_cnt_reg + 1'b1;
        if (evt_cnt_reg == '1) begin
          evt_ovf_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.level_out  = level;
  assign bus.fall_pulse = fall_pulse;
  assign bus.rise_pulse = rise_pulse;
  assign bus.width_out  = width_out_reg;
  assign bus.width_vld  = width_vld_reg;
  assign bus.evt_cnt    = evt_cnt_reg;
  assign bus.evt_ovf    = evt_ovf_reg;

endmodule

// File: tb/tb_debounce_edge.sv
// Two channels (full-size and narrow counters) driven in lockstep; strobe
// timing and latched widths are scored against queued expectations.
module tb_debounce_edge;

  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int fq_a[$];
  int rq_a[$];
  int wq_a[$];
  int fq_b[$];
  int rq_b[$];
  int wq_b[$];

  debounce_edge_if #(.CNT_W(16), .EVT_W(8)) ia ();
  debounce_edge_if #(.CNT_W(4),  .EVT_W(2)) ib ();

  debounce_edge #(.DB_CYCLES(DB), .CNT_W(16), .EVT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  debounce_edge #(.DB_CYCLES(DB), .CNT_W(4), .EVT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("cyc=%0d %s ok value=%0d", cyc, tag, obs);
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic v);
    ia.sync_in = v;
    ib.sync_in = v;
  endtask

  task automatic set_clr(input logic v);
    ia.clr = v;
    ib.clr = v;
  endtask

  task automatic expect_fall(input int at);
    fq_a.push_back(at);
    fq_b.push_back(at);
  endtask

  task automatic expect_rise(input int at, input int w);
    rq_a.push_back(at);
    rq_b.push_back(at);
    wq_a.push_back((w > 65535) ? 65535 : w);
    wq_b.push_back((w > 15) ? 15 : w);
  endtask

  // Low pulse of n cycles followed by gap high cycles; only pulses long
  // enough to qualify are expected to show up at the outputs.
  task automatic low_pulse(input int n, input int gap);
    int c;
    c = cyc;
    set_in(1'b0);
    if (n >= DB) begin
      expect_fall(c + DB);
      expect_rise(c + n + DB, n);
    end
    tick(n);
    set_in(1'b1);
    tick(gap);
  endtask

  task automatic chk_both(input string tag, input logic [31:0] a_obs, input logic [31:0] a_exp,
                          input logic [31:0] b_obs, input logic [31:0] b_exp);
    chk({"a_", tag}, a_obs, a_exp);
    chk({"b_", tag}, b_obs, b_exp);
  endtask

  always @(negedge clk) begin
    int e;
    if (ia.fall_pulse !== 1'b0) begin
      e = (fq_a.size() > 0) ? fq_a.pop_front() : -1;
      chk("a_fall_cyc", cyc, e);
    end
    if (ia.rise_pulse !== 1'b0) begin
      e = (rq_a.size() > 0) ? rq_a.pop_front() : -1;
      chk("a_rise_cyc", cyc, e);
      chk("a_fall_rise_excl", ia.fall_pulse, 1'b0);
    end
    if (ia.width_vld !== 1'b0) begin
      e = (wq_a.size() > 0) ? wq_a.pop_front() : -1;
      chk("a_width", ia.width_out, e);
      chk("a_vld_with_rise", ia.rise_pulse, 1'b1);
    end
  end

  always @(negedge clk) begin
    int e;
    if (ib.fall_pulse !== 1'b0) begin
      e = (fq_b.size() > 0) ? fq_b.pop_front() : -1;
      chk("b_fall_cyc", cyc, e);
    end
    if (ib.rise_pulse !== 1'b0) begin
      e = (rq_b.size() > 0) ? rq_b.pop_front() : -1;
      chk("b_rise_cyc", cyc, e);
      chk("b_fall_rise_excl", ib.fall_pulse, 1'b0);
    end
    if (ib.width_vld !== 1'b0) begin
      e = (wq_b.size() > 0) ? wq_b.pop_front() : -1;
      chk("b_width", ib.width_out, e);
      chk("b_vld_with_rise", ib.rise_pulse, 1'b1);
    end
  end

  initial begin
    int c;
    int r;
    set_in(1'b1);
    set_clr(1'b0);
    rst_n = 1'b0;
    tick(3);
    chk_both("rst_level", ia.level_out, 1, ib.level_out, 1);
    chk_both("rst_fall", ia.fall_pulse, 0, ib.fall_pulse, 0);
    chk_both("rst_rise", ia.rise_pulse, 0, ib.rise_pulse, 0);
    chk_both("rst_width", ia.width_out, 0, ib.width_out, 0);
    chk_both("rst_vld", ia.width_vld, 0, ib.width_vld, 0);
    chk_both("rst_evt", ia.evt_cnt, 0, ib.evt_cnt, 0);
    chk_both("rst_ovf", ia.evt_ovf, 0, ib.evt_ovf, 0);
    rst_n = 1'b1;

    // idle high
    tick(100);
    chk_both("idle_level", ia.level_out, 1, ib.level_out, 1);
    chk_both("idle_evt", ia.evt_cnt, 0, ib.evt_cnt, 0);
    chk_both("idle_width", ia.width_out, 0, ib.width_out, 0);

    // one sample short of qualifying, then chatter inside the filter window
    low_pulse(DB - 1, 40);
    chk_both("short_level", ia.level_out, 1, ib.level_out, 1);
    low_pulse(10, 1);
    low_pulse(10, 40);
    chk_both("chatter_level", ia.level_out, 1, ib.level_out, 1);
    chk_both("chatter_evt", ia.evt_cnt, 0, ib.evt_cnt, 0);

    // qualified pulses; narrow channel saturates width and wraps its count
    low_pulse(40, 40);
    chk_both("p40_evt", ia.evt_cnt, 1, ib.evt_cnt, 1);
    chk_both("p40_width", ia.width_out, 40, ib.width_out, 15);
    low_pulse(100, 40);
    chk_both("p100_width", ia.width_out, 100, ib.width_out, 15);
    low_pulse(20, 30);
    low_pulse(20, 30);
    low_pulse(20, 30);
    chk_both("p5_evt", ia.evt_cnt, 5, ib.evt_cnt, 1);
    chk_both("p5_ovf", ia.evt_ovf, 0, ib.evt_ovf, 1);
    chk_both("p5_width", ia.width_out, 20, ib.width_out, 15);

    // clear while idle
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    chk_both("clr_evt", ia.evt_cnt, 0, ib.evt_cnt, 0);
    chk_both("clr_ovf", ia.evt_ovf, 0, ib.evt_ovf, 0);
    chk_both("clr_width", ia.width_out, 0, ib.width_out, 0);
    chk_both("clr_level", ia.level_out, 1, ib.level_out, 1);

    // clear during a low pulse must not disturb level or width measurement
    c = cyc;
    set_in(1'b0);
    expect_fall(c + DB);
    tick(25);
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    chk_both("clrlo_level", ia.level_out, 0, ib.level_out, 0);
    chk_both("clrlo_evt", ia.evt_cnt, 0, ib.evt_cnt, 0);
    tick(24);
    set_in(1'b1);
    expect_rise(cyc + DB, 50);
    tick(40);
    chk_both("clrlo_width", ia.width_out, 50, ib.width_out, 15);
    chk_both("clrlo_evt2", ia.evt_cnt, 0, ib.evt_cnt, 0);

    // reset while low; held low input must re-qualify from scratch
    c = cyc;
    set_in(1'b0);
    expect_fall(c + DB);
    tick(30);
    chk_both("prerst_evt", ia.evt_cnt, 1, ib.evt_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk_both("midrst_level", ia.level_out, 1, ib.level_out, 1);
    chk_both("midrst_evt", ia.evt_cnt, 0, ib.evt_cnt, 0);
    tick(3);
    rst_n = 1'b1;
    r = cyc;
    expect_fall(r + DB);
    tick(DB - 1);
    chk_both("requal_level_hi", ia.level_out, 1, ib.level_out, 1);
    tick(25);
    chk_both("requal_level", ia.level_out, 0, ib.level_out, 0);
    chk_both("requal_evt", ia.evt_cnt, 1, ib.evt_cnt, 1);
    set_in(1'b1);
    expect_rise(cyc + DB, 40);
    tick(40);
    chk_both("final_level", ia.level_out, 1, ib.level_out, 1);
    chk_both("final_width", ia.width_out, 40, ib.width_out, 15);

    // every queued expectation must have been consumed
    chk_both("left_fall", fq_a.size(), 0, fq_b.size(), 0);
    chk_both("left_rise", rq_a.size(), 0, rq_b.size(), 0);
    chk_both("left_width", wq_a.size(), 0, wq_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
